mem_bist_ctrl: RTL and testbench

MEM_BIST_CTRL -- requirements
Module: mem_bist_ctrl

---
 rtl/mem_bist_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_mem_bist_ctrl.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bist_ctrl.sv
// Memory BIST controller: writes an incrementing pattern (seed + k) over a
// window of locations, reads the window back, compares each returned word
// and reports the miscompare count and the first failing address.
module mem_bist_ctrl #(
   parameter int unsigned WIDTH      = 8,
   parameter int unsigned DEPTH      = 1024,
   parameter int unsigned ADDR_LINES = 10
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  start_i,
   input  logic [ADDR_LINES-1:0] start_addr_i,
   input  logic [ADDR_LINES:0]   num_locs_i,
   input  logic [WIDTH-1:0]      seed_i,
   output logic                  valid_o,
   output logic                  wr_rd_o,
   output logic [ADDR_LINES-1:0] addr_o,
   output logic [WIDTH-1:0]      wr_data_o,
   input  logic [WIDTH-1:0]      rd_data_i,
   input  logic                  ready_i,
   output logic                  busy_o,
   output logic                  done_o,
   output logic                  pass_o,
   output logic [ADDR_LINES:0]   err_cnt_o,
   output logic [ADDR_LINES-1:0] first_err_addr_o,
   output logic                  cfg_err_o
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WRITE,
      S_READ,
      S_DRAIN,
      S_DONE
   } state_e;

   localparam logic [ADDR_LINES+1:0] DEPTH_W = (ADDR_LINES+2)'(DEPTH);
   localparam logic [ADDR_LINES:0]   K_ONE   = (ADDR_LINES+1)'(1);

   state_e                state_q, state_d;
   logic [ADDR_LINES-1:0] start_q, start_d;
   logic [ADDR_LINES:0]   num_q, num_d;
   logic [WIDTH-1:0]      seed_q, seed_d;
   logic [ADDR_LINES:0]   k_q, k_d;
   logic                  cmp_pend_q, cmp_pend_d;
   logic [WIDTH-1:0]      exp_q, exp_d;
   logic [ADDR_LINES-1:0] cmp_addr_q, cmp_addr_d;
   logic [ADDR_LINES:0]   err_cnt_q, err_cnt_d;
   logic [ADDR_LINES-1:0] first_err_q, first_err_d;
   logic                  pass_q, pass_d;
   logic                  cfg_err_q, cfg_err_d;

   logic [ADDR_LINES+1:0] end_sum;
   logic                  cfg_ok;
   logic                  last_k;
   logic [ADDR_LINES-1:0] cur_addr;
   logic [WIDTH-1:0]      pattern;

   // Start validation is done two bits wider so start + num cannot overflow.
   assign end_sum  = {2'b00, start_addr_i} + {1'b0, num_locs_i};
   assign cfg_ok   = (num_locs_i != '0) && (end_sum <= DEPTH_W);
   assign last_k   = (k_q == (num_q - K_ONE));
   assign cur_addr = start_q + k_q[ADDR_LINES-1:0];
   assign pattern  = seed_q + WIDTH'(k_q);

   // State register
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic: each pass advances only on an accepted transfer of the last offset
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start_i && cfg_ok) state_d = S_WRITE;
         S_WRITE: if (ready_i && last_k) state_d = S_READ;
         S_READ:  if (ready_i && last_k) state_d = S_DRAIN;
         S_DRAIN: state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Output decode: memory request and status strobes from the current state
   always_comb begin
      valid_o   = 1'b0;
      wr_rd_o   = 1'b0;
      addr_o    = '0;
      wr_data_o = '0;
      busy_o    = 1'b1;
      done_o    = 1'b0;
      case (state_q)
         S_IDLE: busy_o = 1'b0;
         S_WRITE: begin
            valid_o   = 1'b1;
            wr_rd_o   = 1'b1;
            addr_o    = cur_addr;
            wr_data_o = pattern;
         end
         S_READ: begin
            valid_o = 1'b1;
            addr_o  = cur_addr;
         end
         S_DONE: done_o = 1'b1;
         default: ;
      endcase
   end

   // Datapath next-state: config latch, offset counter, pipelined read compare
   always_comb begin
      start_d     = start_q;
      num_d       = num_q;
      seed_d      = seed_q;
      k_d         = k_q;
      cmp_pend_d  = 1'b0;
      exp_d       = exp_q;
      cmp_addr_d  = cmp_addr_q;
      err_cnt_d   = err_cnt_q;
      first_err_d = first_err_q;
      pass_d      = pass_q;
      cfg_err_d   = 1'b0;

      // Data for a read accepted last edge is on rd_data_i now.
      if (cmp_pend_q && (rd_data_i != exp_q)) begin
         if (err_cnt_q != '1) err_cnt_d = err_cnt_q + K_ONE;
         if (err_cnt_q == '0) first_err_d = cmp_addr_q;
      end

      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               if (cfg_ok) begin
                  start_d     = start_addr_i;
                  num_d       = num_locs_i;
                  seed_d      = seed_i;
                  k_d         = '0;
                  err_cnt_d   = '0;
                  first_err_d = '0;
                  pass_d      = 1'b0;
               end else begin
                  cfg_err_d = 1'b1;
               end
            end
         end
         S_WRITE: begin
            if (ready_i) k_d = last_k ? '0 : k_q + K_ONE;
         end
         S_READ: begin
            if (ready_i) begin
               cmp_pend_d = 1'b1;
               exp_d      = pattern;
               cmp_addr_d = cur_addr;
               k_d        = last_k ? '0 : k_q + K_ONE;
            end
         end
         // The final compare lands on this edge, so pass uses the updated count.
         S_DRAIN: pass_d = (err_cnt_d == '0);
         default: ;
      endcase
   end

   // Datapath registers
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         start_q     <= '0;
         num_q       <= '0;
         seed_q      <= '0;
         k_q         <= '0;
         cmp_pend_q  <= 1'b0;
         exp_q       <= '0;
         cmp_addr_q  <= '0;
         err_cnt_q   <= '0;
         first_err_q <= '0;
         pass_q      <= 1'b0;
         cfg_err_q   <= 1'b0;
      end else begin
         start_q     <= start_d;
         num_q       <= num_d;
         seed_q      <= seed_d;
         k_q         <= k_d;
         cmp_pend_q  <= cmp_pend_d;
         exp_q       <= exp_d;
         cmp_addr_q  <= cmp_addr_d;
         err_cnt_q   <= err_cnt_d;
         first_err_q <= first_err_d;
         pass_q      <= pass_d;
         cfg_err_q   <= cfg_err_d;
      end
   end

   assign pass_o           = pass_q;
   assign err_cnt_o        = err_cnt_q;
   assign first_err_addr_o = first_err_q;
   assign cfg_err_o        = cfg_err_q;

endmodule

// File: tb/tb_mem_bist_ctrl.sv
// Scoreboard bench for mem_bist_ctrl with a behavioural memory model.
module tb_mem_bist_ctrl;

   localparam int W  = 8;
   localparam int D  = 1024;
   localparam int AL = 10;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [AL-1:0] start_addr;
   logic [AL:0]   num;
   logic [W-1:0]  seed;
   logic          valid, wr_rd;
   logic [AL-1:0] addr;
   logic [W-1:0]  wr_data;
   logic [W-1:0]  rd_data;
   logic          ready;
   logic          busy, done, pass;
   logic [AL:0]   err_cnt;
   logic [AL-1:0] first_err;
   logic          cfg_err;

   mem_bist_ctrl #(.WIDTH(W), .DEPTH(D), .ADDR_LINES(AL)) dut (
      .clk_i            (clk),
      .rst_i            (rst),
      .start_i          (start),
      .start_addr_i     (start_addr),
      .num_locs_i       (num),
      .seed_i           (seed),
      .valid_o          (valid),
      .wr_rd_o          (wr_rd),
      .addr_o           (addr),
      .wr_data_o        (wr_data),
      .rd_data_i        (rd_data),
      .ready_i          (ready),
      .busy_o           (busy),
      .done_o           (done),
      .pass_o           (pass),
      .err_cnt_o        (err_cnt),
      .first_err_addr_o (first_err),
      .cfg_err_o        (cfg_err)
   );

   always #5 clk = ~clk;

   int unsigned n_vec = 0;
   int unsigned n_err = 0;
   int unsigned n_valid = 0;
   int unsigned n_done = 0;
   bit          toggle = 1'b0;
   bit          corrupt_en = 1'b0;
   logic [AL-1:0] corrupt_addr = '0;

   // Expected requests: {wr_rd, addr, data}
   logic [AL+W:0] sb[$];

   logic [W-1:0] mem [D];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Memory model: writes store, reads return data on the following cycle
   always @(posedge clk) begin
      if (!rst && valid && ready) begin
         if (wr_rd) mem[addr] <= wr_data;
         else rd_data <= (corrupt_en && addr == corrupt_addr) ? '0 : mem[addr];
      end
   end

   // Ready driver: tied high or toggling each cycle
   initial begin
      ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         ready = toggle ? ~ready : 1'b1;
      end
   end

   // Request monitor: every valid cycle must match the scoreboard head
   always @(negedge clk) begin
      if (!rst) begin
         if (done) n_done++;
         if (valid) begin
            n_valid++;
            if (sb.size() == 0) begin
               check("unexpected_req", sb.size(), 1);
            end else begin
               check("req", {13'b0, wr_rd, addr, wr_data}, {13'b0, sb[0]});
               if (ready) void'(sb.pop_front());
            end
         end
      end
   end

   task automatic do_start(input int sa, input int n, input int sd);
      @(posedge clk);
      #1;
      start_addr = AL'(sa);
      num        = (AL+1)'(n);
      seed       = W'(sd);
      start      = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic push_run(input int sa, input int n, input int sd);
      for (int k = 0; k < n; k++) sb.push_back({1'b1, AL'(sa + k), W'(sd + k)});
      for (int k = 0; k < n; k++) sb.push_back({1'b0, AL'(sa + k), W'(0)});
   endtask

   task automatic wait_done(output int cyc);
      cyc = 0;
      while (!done && cyc < 10000) begin
         @(posedge clk);
         #1;
         cyc++;
      end
   endtask

   task automatic run(input int sa, input int n, input int sd, input bit tog,
                      input bit chk_lat, input bit busy_poke);
      int exp_err = 0;
      int exp_first = 0;
      int cyc;
      for (int k = 0; k < n; k++) begin
         if (corrupt_en && (sa + k) == int'(corrupt_addr) && W'(sd + k) != '0) begin
            if (exp_err == 0) exp_first = sa + k;
            exp_err++;
         end
      end
      push_run(sa, n, sd);
      toggle = tog;
      do_start(sa, n, sd);
      check("busy_after_start", busy, 1);
      if (busy_poke) begin
         start_addr = '1;
         num        = '0;
         start      = 1'b1;
         @(posedge clk);
         #1;
         start = 1'b0;
         check("cfg_err_while_busy", cfg_err, 0);
         @(posedge clk);
         #1;
         check("cfg_err_while_busy2", cfg_err, 0);
      end
      wait_done(cyc);
      check("done_seen", done, 1);
      // start cycle + 4 writes + 4 reads + drain -> done in the 11th cycle
      if (chk_lat) check("done_latency", cyc, 9);
      else if (tog) check("stall_longer", cyc > 9, 1);
      check("pass", pass, exp_err == 0);
      check("err_cnt", err_cnt, exp_err);
      check("first_err", first_err, exp_first);
      check("sb_drained", sb.size(), 0);
      toggle = 1'b0;
      @(posedge clk);
      #1;
      check("done_one_cycle", done, 0);
      check("busy_after_done", busy, 0);
      check("pass_held", pass, exp_err == 0);
      check("err_held", err_cnt, exp_err);
   endtask

   task automatic reject(input int sa, input int n);
      int unsigned v0 = n_valid;
      do_start(sa, n, 8'h55);
      check("cfg_err_pulse", cfg_err, 1);
      check("busy_on_reject", busy, 0);
      @(posedge clk);
      #1;
      check("cfg_err_one_cycle", cfg_err, 0);
      repeat (3) @(posedge clk);
      #1;
      check("no_req_on_reject", n_valid, v0);
   endtask

   initial begin
      int c;
      int unsigned d0, v0;
      rst        = 1'b1;
      start      = 1'b0;
      start_addr = '0;
      num        = '0;
      seed       = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_outputs", {valid, wr_rd, addr, wr_data, busy, done, cfg_err, pass}, 0);
      check("rst_err_cnt", err_cnt, 0);
      check("rst_first_err", first_err, 0);
      rst = 1'b0;
      repeat (2) @(posedge clk);

      run(32'h010, 4, 32'hA5, 1'b0, 1'b1, 1'b0);
      run(32'h010, 4, 32'hA5, 1'b1, 1'b0, 1'b0);

      corrupt_en   = 1'b1;
      corrupt_addr = AL'(12'h012);
      run(32'h010, 4, 32'hA5, 1'b0, 1'b0, 1'b0);
      corrupt_en = 1'b0;

      reject(1020, 5);
      run(1019, 5, 32'hFE, 1'b0, 1'b0, 1'b0);
      run(0, 1024, 32'h3C, 1'b0, 1'b0, 1'b0);
      reject(0, 0);
      run(32'h040, 3, 32'h10, 1'b0, 1'b0, 1'b1);

      // Abort during the read pass
      push_run(32'h100, 8, 32'h33);
      do_start(32'h100, 8, 32'h33);
      c = 0;
      while (!(valid && !wr_rd) && c < 100) begin
         @(posedge clk);
         #1;
         c++;
      end
      check("reached_read", valid && !wr_rd, 1);
      d0 = n_done;
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("async_rst_outputs", {valid, wr_rd, addr, wr_data, busy, done, cfg_err, pass}, 0);
      check("async_rst_err_cnt", err_cnt, 0);
      sb.delete();
      repeat (3) @(posedge clk);
      #1;
      v0  = n_valid;
      rst = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      check("no_done_after_abort", n_done, d0);
      check("idle_without_start", n_valid, v0);
      run(32'h200, 5, 32'h7F, 1'b0, 1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
      $fatal(1);
   end

endmodule
